// File: rtl/cmd_parser_mc_if.sv
// cmd_parser_mc_if -- byte stream in, per-channel waveform settings out.
//   cmd/rd       : ASCII byte and its read strobe from the UART receiver
//   state        : per-channel waveform select, channel k in [8k+7:8k]
//   state_freq   : per-channel frequency word, channel k in [VW*k+VW-1:VW*k]
//   state_amp    : per-channel amplitude word, same packing
//   state_phase  : per-channel phase word, same packing
//   upd/upd_ch   : commit pulse and channel index of the last commit
//   err          : reject pulse
// master = byte source / settings consumer, slave = the parser.
interface cmd_parser_mc_if #(
   parameter int NCH = 2,
   parameter int VW  = 16
);
   logic [7:0]        cmd;
   logic              rd;
   logic [NCH*8-1:0]  state;
   logic [NCH*VW-1:0] state_freq;
   logic [NCH*VW-1:0] state_amp;
   logic [NCH*VW-1:0] state_phase;
   logic              upd;
   logic [3:0]        upd_ch;
   logic              err;

   modport master (
      output cmd, rd,
      input  state, state_freq, state_amp, state_phase, upd, upd_ch, err
   );

   modport slave (
      input  cmd, rd,
      output state, state_freq, state_amp, state_phase, upd, upd_ch, err
   );
endinterface

// File: rtl/cmd_parser_mc.sv
// cmd_parser_mc -- ASCII command parser for a multi-channel waveform generator.
// Commands: <op><ch><1..NDIG decimal digits><CR|LF>, op in {w,f,a,p}.
// Ports:
//   clk : system clock, all logic on the rising edge
//   rst : asynchronous active-high reset
//   bus : cmd_parser_mc_if.slave (cmd/rd in; state, state_freq, state_amp,
//         state_phase, upd, upd_ch, err out)
module cmd_parser_mc #(
   parameter int NCH       = 2,
   parameter int NDIG      = 4,
   parameter int VW        = 16,
   parameter int DEF_STATE = 3
) (
   input  logic            clk,
   input  logic            rst,
   cmd_parser_mc_if.slave  bus
);

   localparam int             AW      = VW + 4;
   localparam logic [AW-1:0]  ACC_MAX = {4'b0000, {VW{1'b1}}};

   typedef enum logic [1:0] {IDLE, CHAN, DIGIT, ERROR} fsm_t;
   typedef enum logic [1:0] {OP_W, OP_F, OP_A, OP_P} op_t;

   fsm_t          fsm_q, fsm_d;
   op_t           op_q, op_d, byte_op;
   logic [3:0]    ch_q, ch_d;
   logic [AW-1:0] acc_q, acc_d, acc_mac;
   logic [3:0]    cnt_q, cnt_d;
   logic          rd_q, armed_q;
   logic          accept, is_op, is_term, is_digit, is_ch;
   logic          commit, reject;
   logic          upd_q, err_q;
   logic [3:0]    upd_ch_q;

   logic [7:0]    wave_q  [NCH];
   logic [VW-1:0] freq_q  [NCH];
   logic [VW-1:0] amp_q   [NCH];
   logic [VW-1:0] phase_q [NCH];

   // armed_q stays low after reset until rd has been seen low, so a strobe
   // already high when reset releases is not mistaken for a new byte.
   assign accept = bus.rd & ~rd_q & armed_q;

   // The accumulator is held at or below ACC_MAX, so acc*10+9 always fits
   // in AW bits and the compare below gives sticky saturation.
   assign acc_mac = acc_q * AW'(10) + AW'(bus.cmd[3:0]);

   always_comb begin
      is_op   = 1'b1;
      byte_op = OP_W;
      case (bus.cmd)
         "w":     byte_op = OP_W;
         "f":     byte_op = OP_F;
         "a":     byte_op = OP_A;
         "p":     byte_op = OP_P;
         default: is_op = 1'b0;
      endcase
      is_term  = (bus.cmd == 8'h0D) || (bus.cmd == 8'h0A);
      is_digit = (bus.cmd >= 8'h30) && (bus.cmd <= 8'h39);
      is_ch    = (bus.cmd >= 8'h30) && (bus.cmd < 8'(8'h30 + NCH));
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      fsm_d  = fsm_q;
      op_d   = op_q;
      ch_d   = ch_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      commit = 1'b0;
      reject = 1'b0;
      if (accept) begin
         if (is_op) begin
            // An op always starts a fresh command, aborting any pending one.
            op_d  = byte_op;
            fsm_d = CHAN;
         end else begin
            unique case (fsm_q)
               IDLE: begin
                  if (!is_term) begin
                     reject = 1'b1;
                     fsm_d  = ERROR;
                  end
               end
               CHAN: begin
                  if (is_ch) begin
                     ch_d  = bus.cmd[3:0];
                     acc_d = '0;
                     cnt_d = '0;
                     fsm_d = DIGIT;
                  end else begin
                     reject = 1'b1;
                     fsm_d  = ERROR;
                  end
               end
               DIGIT: begin
                  if (is_digit && (cnt_q < 4'(NDIG))) begin
                     acc_d = (acc_mac > ACC_MAX) ? ACC_MAX : acc_mac;
                     cnt_d = cnt_q + 4'd1;
                  end else if (is_term && (cnt_q != 4'd0)) begin
                     commit = 1'b1;
                     fsm_d  = IDLE;
                  end else begin
                     reject = 1'b1;
                     fsm_d  = ERROR;
                  end
               end
               ERROR: begin
                  if (is_term) fsm_d = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q    <= IDLE;
         rd_q     <= 1'b0;
         armed_q  <= 1'b0;
         op_q     <= OP_W;
         ch_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         upd_q    <= 1'b0;
         err_q    <= 1'b0;
         upd_ch_q <= '0;
         // NOTE: the per-channel arrays are plain flops with defined
         // power-up settings, not RAM, so they belong in the reset branch.
         for (int k = 0; k < NCH; k++) begin
            wave_q[k]  <= 8'(DEF_STATE);
            freq_q[k]  <= VW'(1);
            amp_q[k]   <= VW'(1);
            phase_q[k] <= VW'(1);
         end
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge
         // values, independent of statement order in this block.
         fsm_q   <= fsm_d;
         rd_q    <= bus.rd;
         armed_q <= armed_q | ~bus.rd;
         op_q    <= op_d;
         ch_q    <= ch_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         upd_q   <= commit;
         err_q   <= reject;
         if (commit) upd_ch_q <= ch_q;
         for (int k = 0; k < NCH; k++) begin
            if (commit && (ch_q == 4'(k))) begin
               case (op_q)
                  OP_W: wave_q[k]  <= 8'(acc_q[VW-1:0]);
                  OP_F: freq_q[k]  <= acc_q[VW-1:0];
                  OP_A: amp_q[k]   <= acc_q[VW-1:0];
                  OP_P: phase_q[k] <= acc_q[VW-1:0];
               endcase
            end
         end
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_pack
      assign bus.state[8*k +: 8]         = wave_q[k];
      assign bus.state_freq[VW*k +: VW]  = freq_q[k];
      assign bus.state_amp[VW*k +: VW]   = amp_q[k];
      assign bus.state_phase[VW*k +: VW] = phase_q[k];
   end

   assign bus.upd    = upd_q;
   assign bus.err    = err_q;
   assign bus.upd_ch = upd_ch_q;

endmodule
